// File: rtl/vram_seq_pkg.sv
// Shared definitions for the VRAM timing sequencer: FSM state codes,
// cycle-type encoding and the strobe bundle.
package vram_seq_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ROW  = 3'd1;
  localparam logic [2:0] S_COL  = 3'd2;
  localparam logic [2:0] S_XOE  = 3'd3;
  localparam logic [2:0] S_PRE  = 3'd4;
  localparam logic [2:0] S_REF  = 3'd5;

  typedef enum logic [1:0] {
    CYC_RD   = 2'd0,
    CYC_WR   = 2'd1,
    CYC_XFER = 2'd2,
    CYC_REF  = 2'd3
  } cyc_t;

  // Active-low DRAM control strobes; '1 is the idle (precharge) pattern.
  typedef struct packed {
    logic ras;
    logic cas;
    logic we;
    logic oe;
  } strobe_t;

  function automatic logic [7:0] row_of(input logic [15:0] addr);
    return addr[15:8];
  endfunction

  function automatic logic [7:0] col_of(input logic [15:0] addr);
    return addr[7:0];
  endfunction

endpackage

// File: rtl/vram_seq_if.sv
// Host-side handshake bundle of the sequencer: byte access, read response
// and row-transfer request.
interface vram_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        xfer_valid;
  logic        xfer_ready;
  logic [15:0] xfer_addr;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, xfer_valid, xfer_addr,
    input  req_ready, rsp_valid, rsp_rdata, xfer_ready
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, xfer_valid, xfer_addr,
    output req_ready, rsp_valid, rsp_rdata, xfer_ready
  );
endinterface

// File: rtl/vram_refresh_timer.sv
// Free-running refresh interval counter with a single-entry pending flag
// and the 8-bit RAS-only refresh row pointer.
module vram_refresh_timer #(
  parameter int unsigned REF_INTERVAL = 128
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       clr_pending,
  input  logic       inc_row,
  output logic       pending,
  output logic [7:0] row
);

  localparam int unsigned CW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(REF_INTERVAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [7:0]    row_q, row_d;
  logic          expire;

  // NOTE: every variable gets its default at the top of always_comb, so no path leaves it unassigned and infers a latch.
  always_comb begin
    expire = (cnt_q == LAST);
    cnt_d  = expire ? '0 : cnt_q + CW'(1);
    pend_d = pend_q;
    if (expire) pend_d = 1'b1;
    // Clearing wins: an expiry landing while a refresh is already owed is absorbed.
    if (clr_pending) pend_d = 1'b0;
    row_d  = inc_row ? row_q + 8'd1 : row_q;
  end

  // NOTE: flops use non-blocking assignments so every register samples its pre-edge inputs.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      row_q  <= 8'd0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      row_q  <= row_d;
    end
  end

  assign pending = pend_q;
  assign row     = row_q;

endmodule

// File: rtl/vram_seq.sv
// Dual-port VRAM timing sequencer: arbitrates refresh, row transfer and
// byte access into registered RAS/CAS/WE/OE sequences, plus a serial-clock pulser.
module vram_seq
  import vram_seq_pkg::*;
#(
  parameter int unsigned T_RCD        = 2,
  parameter int unsigned T_CAS        = 2,
  parameter int unsigned T_RP         = 2,
  parameter int unsigned REF_INTERVAL = 128,
  parameter int unsigned T_REF        = 2
) (
  input  logic       MCLK,
  input  logic       reset,
  vram_seq_if.slave  host,
  input  logic       sc_req,
  output logic       sc_busy,
  input  logic       sd_enable,
  output logic       ram_RAS,
  output logic       ram_CAS,
  output logic       ram_WE,
  output logic       ram_OE,
  output logic       ram_SC,
  output logic       ram_SE,
  output logic [7:0] ram_AD,
  output logic [7:0] ram_RD_o,
  output logic       ram_RD_d,
  input  logic [7:0] ram_RD_i
);

  logic [2:0]  state_q, state_d;
  cyc_t        cyc_q, cyc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  strobe_t     stb_q, stb_d;
  logic [7:0]  ad_q, ad_d, rdo_q, rdo_d;
  logic        rdd_q, rdd_d, se_q, se_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  sc_q, sc_d;
  logic        ref_pending, ref_clr, ref_inc;
  logic [7:0]  ref_row;
  logic        cas_last, xfer_hold;

  vram_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref (
    .MCLK        (MCLK),
    .reset       (reset),
    .clr_pending (ref_clr),
    .inc_row     (ref_inc),
    .pending     (ref_pending),
    .row         (ref_row)
  );

  always_comb begin
    state_d         = state_q;
    cyc_d           = cyc_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    host.req_ready  = 1'b0;
    host.xfer_ready = 1'b0;
    ref_clr         = 1'b0;
    ref_inc         = 1'b0;
    cas_last        = (cnt_q == 8'(T_CAS - 1));
    case (state_q)
      S_IDLE: if (!reset) begin
        if (ref_pending) begin
          state_d = S_REF;
          cyc_d   = CYC_REF;
          ref_clr = 1'b1;
        end else if (host.xfer_valid) begin
          host.xfer_ready = 1'b1;
          state_d         = S_ROW;
          cyc_d           = CYC_XFER;
          addr_d          = host.xfer_addr;
        end else if (host.req_valid) begin
          host.req_ready = 1'b1;
          state_d        = S_ROW;
          cyc_d          = host.req_wr ? CYC_WR : CYC_RD;
          addr_d         = host.req_addr;
          wdata_d        = host.req_wdata;
        end
      end
      S_ROW: if (cnt_q == 8'(T_RCD - 1)) state_d = S_COL;
      // A transfer only needs one CAS cycle before OE is raised to fire the load.
      S_COL: begin
        if (cyc_q == CYC_XFER) state_d = S_XOE;
        else if (cas_last)     state_d = S_PRE;
      end
      S_XOE: state_d = S_PRE;
      S_PRE: if (cnt_q == 8'(T_RP - 1)) state_d = S_IDLE;
      S_REF: if (cnt_q == 8'(T_REF - 1)) begin
        state_d = S_PRE;
        ref_inc = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;

    rsp_valid_d = (state_q == S_COL) && (cyc_q == CYC_RD) && cas_last;
    rsp_rdata_d = rsp_valid_d ? ram_RD_i : rsp_rdata_q;
  end

  // Strobes are decoded from the next state and registered, so pins change only on MCLK.
  always_comb begin
    stb_d = '1;
    ad_d  = ad_q;
    rdo_d = rdo_q;
    rdd_d = 1'b1;
    case (state_d)
      S_ROW: begin
        stb_d.ras = 1'b0;
        stb_d.oe  = (cyc_d != CYC_XFER);
        ad_d      = row_of(addr_d);
      end
      S_COL: begin
        stb_d.ras = 1'b0;
        stb_d.cas = 1'b0;
        ad_d      = col_of(addr_d);
        if (cyc_d == CYC_WR) begin
          stb_d.we = 1'b0;
          rdd_d    = 1'b0;
          rdo_d    = wdata_d;
        end else begin
          stb_d.oe = 1'b0;
        end
      end
      S_XOE: begin
        stb_d.ras = 1'b0;
        stb_d.cas = 1'b0;
      end
      S_REF: begin
        stb_d.ras = 1'b0;
        ad_d      = ref_row;
      end
      default: ;
    endcase
  end

  always_comb begin
    xfer_hold = ((state_q == S_COL) && (cyc_q == CYC_XFER)) || (state_q == S_XOE);
    sc_busy   = (sc_q != 2'b00) || xfer_hold;
    case (sc_q)
      2'b00:   sc_d = (sc_req && !sc_busy) ? 2'b01 : 2'b00;
      2'b01:   sc_d = 2'b10;
      default: sc_d = 2'b00;
    endcase
    se_d = ~sd_enable;
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cyc_q       <= CYC_RD;
      cnt_q       <= 8'd0;
      addr_q      <= 16'd0;
      wdata_q     <= 8'd0;
      stb_q       <= '1;
      ad_q        <= 8'd0;
      rdo_q       <= 8'd0;
      rdd_q       <= 1'b1;
      se_q        <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'd0;
      sc_q        <= 2'b00;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      stb_q       <= stb_d;
      ad_q        <= ad_d;
      rdo_q       <= rdo_d;
      rdd_q       <= rdd_d;
      se_q        <= se_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      sc_q        <= sc_d;
    end
  end

  assign ram_RAS        = stb_q.ras;
  assign ram_CAS        = stb_q.cas;
  assign ram_WE         = stb_q.we;
  assign ram_OE         = stb_q.oe;
  assign ram_SC         = sc_q[0];
  assign ram_SE         = se_q;
  assign ram_AD         = ad_q;
  assign ram_RD_o       = rdo_q;
  assign ram_RD_d       = rdd_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/vram_seq.md
Name: vram_seq

Overview:
- Timing sequencer directly upstream of the dual-port VRAM model; sole driver of its RAS/CAS/WE/OE/SC/SE/AD/RD pins.
- Converts a valid/ready byte-access interface, a row-transfer request and serial-shift pulses into multiplexed-address DRAM strobe sequences.
- Inserts periodic RAS-only refresh.
- All strobes are registered on MCLK; the VRAM detects edges on MCLK, so each strobe level is held for at least one full cycle.

Parameters:
- T_RCD, 2: cycles RAS low before CAS falls (≥1).
- T_CAS, 2: cycles CAS low for read/write (≥2; read data is captured in the last cycle).
- T_RP, 2: cycles of precharge (RAS/CAS high) after every cycle type (≥1).
- REF_INTERVAL, 128: MCLK cycles between refresh requests.
- T_REF, 2: cycles RAS low during refresh.

Ports:
- MCLK  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  byte access request
- req_ready  out  1  request accepted this cycle
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  16  [15:8] row, [7:0] column
- req_wdata  in  8  write byte
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  8  read byte
- xfer_valid  in  1  row to serial register transfer request
- xfer_ready  out  1  transfer accepted
- xfer_addr  in  16  row / serial start column
- sc_req  in  1  request one serial shift (pulse)
- sc_busy  out  1  shift in progress, sc_req ignored
- sd_enable  in  1  1 = VRAM drives serial data
- ram_RAS, ram_CAS, ram_WE, ram_OE  out  1 each  active-low strobes
- ram_SC  out  1  serial clock
- ram_SE  out  1  serial output disable (= ~sd_enable, registered)
- ram_AD  out  8  multiplexed address
- ram_RD_o  out  8  write data to VRAM
- ram_RD_d  out  1  1 = write data not driven
- ram_RD_i  in  8  read data from VRAM

Behaviour:
- Reset values:
  - RAS, CAS, WE, OE = 1; SC = 0; SE = 1; AD = 0; RD_o = 0; RD_d = 1.
  - req_ready, xfer_ready, rsp_valid, sc_busy = 0; rsp_rdata = 0.
  - Refresh row counter = 0; interval counter = 0; FSM in IDLE.
- Reset mid-cycle: the next cycle all strobes are inactive, the operation in flight is dropped, no rsp_valid is produced, and a pending refresh is cleared.
- FSM states: IDLE, ROW, COL, XOE, PRE, REF.
- IDLE arbitration, fixed priority: refresh pending > xfer_valid > req_valid.
  - Ready is asserted combinationally only for the winner, only in IDLE.
  - Address and data are latched on the accept cycle.
- ROW (T_RCD cycles): AD = row, RAS = 0.
  - For a transfer, OE = 0 in the same cycle RAS falls, so the VRAM samples dt = 1.
  - For read/write, OE = 1 and WE = 1.
- COL (T_CAS cycles): AD = column, CAS = 0.
  - Read: OE = 0. On the last COL cycle, rsp_rdata <= ram_RD_i and rsp_valid pulses the following cycle.
  - Write: WE = 0, RD_d = 0, RD_o = wdata for all of COL.
  - Transfer: OE stays 0 for 1 cycle only, then go to XOE.
- XOE (1 cycle): OE = 1 with RAS/CAS still low; this rising OE edge triggers the serial load. Next state PRE.
- PRE (T_RP cycles): RAS = CAS = WE = OE = 1, RD_d = 1. Next state IDLE.
- REF (T_REF cycles):
  - AD = refresh row, RAS = 0, CAS/OE/WE = 1.
  - Refresh row increments by 1 mod 256 on exit, wrapping 255 to 0. Then go to PRE.
- Refresh interval counter:
  - Counts every cycle and sets refresh-pending on reaching REF_INTERVAL-1, then wraps to 0.
  - Pending is cleared on entering REF. A second expiry while pending does not queue a second refresh.
- Serial shift (independent of the FSM):
  - sc_req while !sc_busy gives SC = 1 for 1 cycle, then SC = 0 for 1 cycle; sc_busy is high for both cycles.
  - sc_req while busy, or while FSM is in COL(xfer) or XOE, is dropped. During those states sc_busy is forced to 1.
- Simultaneous xfer_valid and req_valid: the transfer is served first; req_valid must be held by the requester.
- ram_SE is updated every cycle from sd_enable, including during reset release.
- Counters are modular with no saturation. Address widths are fixed at 8+8.

Decomposition:
- Package vram_seq_pkg: FSM state enum and the cycle-type encoding (RD, WR, XFER, REF).
- One natural sub-module: vram_refresh_timer (interval counter, pending flag, 8-bit row counter).
- The serial-shift pulse generator stays inline.

Test Plan:
- Write then read: write 0x5A to addr 0x1234, then read 0x1234 (defaults) → ram_AD = 0x12 with RAS low for 2 cycles, then 0x34 with CAS low for 2 cycles. The write has WE = 0 and RD_d = 0; the read returns rsp_rdata = 0x5A with a single rsp_valid pulse 5 cycles after accept.
- Transfer plus shifts: write 0xA1 at 0x0710, transfer at 0x0710, then 3 sc_req pulses with sd_enable = 1 → serial outputs 0xA1, then bytes from columns 0x11 and 0x12; the OE low→high edge occurs with RAS/CAS low.
- Refresh: REF_INTERVAL = 16 with no traffic → a RAS-only cycle every 16 cycles with AD = 0, 1, 2, …; after 256 refreshes AD wraps to 0. CAS never asserts.
- Arbitration: req_valid and xfer_valid high together at refresh expiry → order is REF, XFER, RD; each cycle is separated by T_RP cycles of precharge.
- Reset mid-read (asserted during COL) → the next cycle RAS/CAS/OE = 1 and RD_d = 1, no rsp_valid, refresh row = 0.
- SC during transfer: sc_req in the XOE cycle → dropped, SC stays 0, sc_busy = 1; a new sc_req after PRE produces a 1-cycle SC pulse.
